// File: rtl/cd_serial.sv
// Byte-wide NRZ serial transmitter: start bit, 8 data bits LSB first, optional odd parity, stop.
// Define CD_PARITY_EN to build the parity bit into the frame (11 bits instead of 10).
module cd_serial #(
    parameter int unsigned BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       d_rdy,
    output logic       busy,
    output logic       tx,
    output logic       done
);

    localparam int unsigned DivW = $clog2(BIT_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);

`ifdef CD_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state;
    logic [DivW-1:0] div_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [2:0]      bit_nxt;

    assign bit_nxt = bit_idx + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == StIdle) begin
                if (d_rdy) begin
                    shreg   <= d;
                    busy    <= 1'b1;
                    tx      <= 1'b0;
                    div_cnt <= '0;
                    state   <= StStart;
                end
            end else if (div_cnt != DivLast) begin
                div_cnt <= div_cnt + DivW'(1);
            end else begin
                // Bit boundary: reload the divider and present the next bit.
                div_cnt <= '0;
                case (state)
                    StStart: begin
                        state   <= StData;
                        bit_idx <= 3'd0;
                        tx      <= shreg[0];
                    end
                    StData: begin
                        if (bit_idx == 3'd7) begin
`ifdef CD_PARITY_EN
                            state <= StParity;
                            tx    <= ~^shreg;
`else
                            state <= StStop;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_nxt;
                            tx      <= shreg[bit_nxt];
                        end
                    end
`ifdef CD_PARITY_EN
                    StParity: begin
                        state <= StStop;
                        tx    <= 1'b1;
                    end
`endif
                    StStop: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cd_serial.sv
// Randomized self-checking bench for cd_serial against a frame-level reference model.
module tb_cd_serial;

    localparam int BD = 4;
`ifdef CD_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 10 + P;
    localparam int FL    = NBITS * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       d_rdy;
    logic       busy;
    logic       tx;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int rises    = 0;
    int dones    = 0;
    logic busy_prev = 1'b0;

    cd_serial #(.BIT_DIV(BD)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .d_rdy (d_rdy),
        .busy  (busy),
        .tx    (tx),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (busy && !busy_prev) rises <= rises + 1;
        if (done) dones <= dones + 1;
        busy_prev <= busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit i of byte b: start, data LSB first, optional odd parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int ones = 0;
        for (int j = 0; j < 8; j++) ones += int'(b[j]);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (P == 1 && i == 9) return (ones % 2 == 0);
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle; the following posedge captures b.
    task automatic run_frame(input logic [7:0] b, input bit keep_rdy, input logic [7:0] next_d);
        d     = b;
        d_rdy = 1'b1;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            check($sformatf("tx[%0h] bit%0d", b, k / BD), 32'(tx), 32'(exp_bit(b, k / BD)));
            check("busy in frame", 32'(busy), 32'd1);
            check("done in frame", 32'(done), 32'd0);
            if (k == BD * 5) d = next_d;
            if (keep_rdy) d_rdy = 1'b1;
            else if (k < FL - 2) d_rdy = 1'($urandom % 2);
            else d_rdy = 1'b0;
        end
        @(negedge clk);
        check("busy at end", 32'(busy), 32'd0);
        check("done at end", 32'(done), 32'd1);
        check("tx at end", 32'(tx), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle tx", 32'(tx), 32'd1);
            check("idle busy", 32'(busy), 32'd0);
            check("idle done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        logic [7:0] b;
        rst   = 1'b1;
        d     = 8'h00;
        d_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;

        // First edge after reset release captures.
        run_frame(8'hA5, 1'b0, 8'h00);
        idle_cycles(2);
        run_frame(8'h01, 1'b0, 8'hFE);
        idle_cycles(1);
        run_frame(8'hFF, 1'b0, 8'h00);
        idle_cycles(1);
        run_frame(8'h00, 1'b0, 8'hFF);
        idle_cycles(1);
        run_frame(8'h3C, 1'b0, 8'hC3);
        idle_cycles(20);

        r0 = rises;
        d0 = dones;
        run_frame(8'h11, 1'b1, 8'h22);
        run_frame(8'h22, 1'b0, 8'h33);
        idle_cycles(1);
        check("b2b busy rises", 32'(rises - r0), 32'd2);
        check("b2b done pulses", 32'(dones - d0), 32'd2);

        // Abort during data bit 3.
        d     = 8'h96;
        d_rdy = 1'b1;
        @(negedge clk);
        d_rdy = 1'b0;
        repeat (4 * BD + 1) @(negedge clk);
        check("pre-abort busy", 32'(busy), 32'd1);
        check("pre-abort tx", 32'(tx), 32'(exp_bit(8'h96, 4)));
        d0 = dones;
        #2 rst = 1'b1;
        #1;
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort no done", 32'(dones - d0), 32'd0);
        run_frame(8'h5A, 1'b0, 8'h00);
        idle_cycles(1);

        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom);
            run_frame(b, 1'b0, 8'($urandom));
            idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
